// File: rtl/chess_pkg.sv
// Shared chess types: piece encoding, colours, executor states and the
// reset value of every board square.
package chess_pkg;

    typedef enum logic [2:0] {
        NONE   = 3'd0,
        PAWN   = 3'd1,
        KNIGHT = 3'd2,
        BISHOP = 3'd3,
        ROOK   = 3'd4,
        QUEEN  = 3'd5,
        KING   = 3'd6
    } kind_t;

    typedef struct packed {
        kind_t kind;
        logic  black;
        logic  occ;
    } piece_t;

    localparam logic   WHITE = 1'b0;
    localparam logic   BLACK = 1'b1;
    localparam piece_t EMPTY = '0;

    typedef enum logic [2:0] {
        IDLE,
        QUERY,
        PICK_DST,
        WRITE_DST,
        CLEAR_SRC,
        OVER
    } state_t;

    function automatic piece_t start_piece(
        input logic [2:0] row,
        input logic [2:0] col
    );
        piece_t p;
        kind_t  back;
        case (col)
            3'd0, 3'd7: back = ROOK;
            3'd1, 3'd6: back = KNIGHT;
            3'd2, 3'd5: back = BISHOP;
            3'd3:       back = QUEEN;
            default:    back = KING;
        endcase
        p = EMPTY;
        if (row == 3'd0 || row == 3'd7) begin
            p.kind = back;
            p.occ  = 1'b1;
        end else if (row == 3'd1 || row == 3'd6) begin
            p.kind = PAWN;
            p.occ  = 1'b1;
        end
        // Rows 0..3 belong to black.
        if (p.occ)
            p.black = (row[2] == 1'b0) ? BLACK : WHITE;
        return p;
    endfunction

endpackage

// File: rtl/move_executor_board_ram.sv
// 64-entry board register file: async reset to the start position,
// one write port, a combinational lookup and a registered renderer read.
module board_ram
    import chess_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [5:0] waddr,
    input  piece_t     wdata,
    input  logic [5:0] faddr,
    output piece_t     fdata,
    input  logic [5:0] raddr,
    output piece_t     rdata
);

    piece_t mem [64];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++)
                mem[i] <= start_piece(i[5:3], i[2:0]);
            rdata <= EMPTY;
        end else begin
            if (we)
                mem[waddr] <= wdata;
            rdata <= mem[raddr];
        end
    end

    assign fdata = mem[faddr];

endmodule

// File: rtl/move_executor.sv
// Board owner: turns cursor selections into committed moves, queries the
// legal-move generator and serves the renderer.
module move_executor
    import chess_pkg::*;
#(
    parameter int QUERY_TIMEOUT = 255,
    parameter int MOVE_CNT_W    = 10
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            cur_row,
    input  logic [2:0]            cur_col,
    input  logic                  select,
    input  logic                  cancel,
    input  logic [63:0]           legal_mask,
    input  logic                  legal_valid,
    output logic [2:0]            src_row,
    output logic [2:0]            src_col,
    output logic                  src_valid,
    input  logic [2:0]            rd_row,
    input  logic [2:0]            rd_col,
    output logic [4:0]            rd_piece,
    output logic                  turn,
    output logic                  sel_active,
    output logic                  move_done,
    output logic                  illegal,
    output logic                  game_over,
    output logic [MOVE_CNT_W-1:0] move_count
);

    localparam logic [7:0] TO_LAST = 8'(QUERY_TIMEOUT - 1);

    state_t     state, state_n;
    piece_t     cur_piece, src_piece, wdata, rd_data;
    logic [5:0] cur_idx, src_idx, dst_idx, waddr;
    logic [63:0] mask;
    logic [7:0] timer;
    logic       dst_king;
    logic       we, latch_src, latch_dst, take_mask, timer_inc;
    logic       illegal_n, done_n, capture_king;
    logic       own, on_src, promote;

    board_ram u_board (
        .clk   (clk),
        .reset (reset),
        .we    (we),
        .waddr (waddr),
        .wdata (wdata),
        .faddr (cur_idx),
        .fdata (cur_piece),
        .raddr ({rd_row, rd_col}),
        .rdata (rd_data)
    );

    assign cur_idx = {cur_row, cur_col};
    assign own     = cur_piece.occ && (cur_piece.black == turn);
    assign on_src  = (cur_idx == src_idx);
    // A pawn reaching the far rank becomes a queen.
    assign promote = (src_piece.kind == PAWN) &&
                     ((!src_piece.black && dst_idx[5:3] == 3'd0) ||
                      ( src_piece.black && dst_idx[5:3] == 3'd7));

    always_comb begin
        state_n      = state;
        we           = 1'b0;
        waddr        = dst_idx;
        wdata        = EMPTY;
        latch_src    = 1'b0;
        latch_dst    = 1'b0;
        take_mask    = 1'b0;
        timer_inc    = 1'b0;
        illegal_n    = 1'b0;
        done_n       = 1'b0;
        capture_king = 1'b0;
        unique case (state)
            IDLE: begin
                if (select) begin
                    if (own) begin
                        latch_src = 1'b1;
                        state_n   = QUERY;
                    end else begin
                        illegal_n = 1'b1;
                    end
                end
            end
            QUERY: begin
                if (legal_valid) begin
                    take_mask = 1'b1;
                    state_n   = PICK_DST;
                end else if (timer == TO_LAST) begin
                    illegal_n = 1'b1;
                    state_n   = IDLE;
                end else begin
                    timer_inc = 1'b1;
                end
            end
            PICK_DST: begin
                if (cancel) begin
                    state_n = IDLE;
                end else if (select) begin
                    if (on_src) begin
                        state_n = IDLE;
                    end else if (own) begin
                        latch_src = 1'b1;
                        state_n   = QUERY;
                    end else if (mask[cur_idx]) begin
                        latch_dst = 1'b1;
                        state_n   = WRITE_DST;
                    end else begin
                        illegal_n = 1'b1;
                    end
                end
            end
            WRITE_DST: begin
                we           = 1'b1;
                waddr        = dst_idx;
                wdata        = src_piece;
                if (promote)
                    wdata.kind = QUEEN;
                capture_king = dst_king;
                state_n      = CLEAR_SRC;
            end
            CLEAR_SRC: begin
                we      = 1'b1;
                waddr   = src_idx;
                wdata   = EMPTY;
                done_n  = 1'b1;
                state_n = game_over ? OVER : IDLE;
            end
            OVER: begin
                state_n = OVER;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            src_idx    <= '0;
            src_piece  <= EMPTY;
            dst_idx    <= '0;
            dst_king   <= 1'b0;
            mask       <= '0;
            timer      <= '0;
            turn       <= WHITE;
            game_over  <= 1'b0;
            move_count <= '0;
            illegal    <= 1'b0;
            move_done  <= 1'b0;
        end else begin
            if (latch_src) begin
                src_idx   <= cur_idx;
                src_piece <= cur_piece;
                timer     <= '0;
            end
            if (timer_inc)
                timer <= timer + 8'd1;
            if (take_mask)
                mask <= legal_mask;
            if (latch_dst) begin
                dst_idx  <= cur_idx;
                dst_king <= cur_piece.occ && (cur_piece.kind == KING);
            end
            if (capture_king)
                game_over <= 1'b1;
            if (done_n) begin
                turn <= ~turn;
                if (move_count != '1)
                    move_count <= move_count + MOVE_CNT_W'(1);
            end
            illegal   <= illegal_n;
            move_done <= done_n;
        end
    end

    assign src_row    = src_idx[5:3];
    assign src_col    = src_idx[2:0];
    assign src_valid  = (state == QUERY);
    assign sel_active = (state == PICK_DST);
    assign rd_piece   = rd_data;

endmodule

// File: tb/tb_move_executor.sv
// Scoreboard bench for move_executor: scripted and random games checked
// against a square-array chess model.
module tb_move_executor;

    localparam int QT = 20;
    localparam int CW = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [2:0]  cur_row = '0, cur_col = '0;
    logic        select = 1'b0, cancel = 1'b0;
    logic [63:0] legal_mask = '0;
    logic        legal_valid = 1'b0;
    logic [2:0]  src_row, src_col;
    logic        src_valid;
    logic [2:0]  rd_row = '0, rd_col = '0;
    logic [4:0]  rd_piece;
    logic        turn, sel_active, move_done, illegal, game_over;
    logic [CW-1:0] move_count;

    always #5 clk = ~clk;

    move_executor #(.QUERY_TIMEOUT(QT), .MOVE_CNT_W(CW)) dut (
        .clk(clk), .reset(reset),
        .cur_row(cur_row), .cur_col(cur_col),
        .select(select), .cancel(cancel),
        .legal_mask(legal_mask), .legal_valid(legal_valid),
        .src_row(src_row), .src_col(src_col), .src_valid(src_valid),
        .rd_row(rd_row), .rd_col(rd_col), .rd_piece(rd_piece),
        .turn(turn), .sel_active(sel_active),
        .move_done(move_done), .illegal(illegal),
        .game_over(game_over), .move_count(move_count)
    );

    typedef struct {
        bit mv;
        bit t;
        int cnt;
        bit ov;
    } ev_t;

    ev_t        evq[$];
    logic [4:0] rdq[$];
    logic [4:0] board [64];
    bit         mturn, mover;
    int         mcount;
    int         n_pass = 0, n_total = 0;
    logic       rd_go = 1'b0, rd_go_d = 1'b0;

    task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [4:0] ref_start(int r, int c);
        string back = "RNBQKBNR";
        byte   ch;
        int    code;
        if (r == 1 || r == 6) return {3'd1, r < 4, 1'b1};
        if (r != 0 && r != 7) return 5'd0;
        ch = back[c];
        case (ch)
            "R": code = 4;
            "N": code = 2;
            "B": code = 3;
            "Q": code = 5;
            default: code = 6;
        endcase
        return {3'(code), r < 4, 1'b1};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 64; i++) board[i] = ref_start(i / 8, i % 8);
        mturn = 0; mcount = 0; mover = 0;
    endtask

    function automatic bit own(int i);
        return board[i][0] && (board[i][1] == mturn);
    endfunction

    task automatic apply_move(int s, int d);
        logic [4:0] p;
        p = board[s];
        if (p[4:2] == 3'd1 && ((!p[1] && d / 8 == 0) || (p[1] && d / 8 == 7)))
            p[4:2] = 3'd5;
        if (board[d][0] && board[d][4:2] == 3'd6) mover = 1;
        board[d] = p;
        board[s] = 5'd0;
        mturn = !mturn;
        if (mcount < (1 << CW) - 1) mcount++;
        evq.push_back('{1, mturn, mcount, mover});
    endtask

    task automatic push_ill();
        evq.push_back('{0, 0, 0, 0});
    endtask

    always @(posedge clk) rd_go_d <= rd_go;

    initial begin : monitor
        ev_t e;
        bit have;
        logic [1:0] ek;
        forever begin
            @(negedge clk);
            if (!reset && (illegal || move_done)) begin
                have = evq.size() > 0;
                if (have) e = evq.pop_front();
                ek = !have ? 2'b00 : (e.mv ? 2'b01 : 2'b10);
                chk("pulse_kind", {illegal, move_done}, ek);
                if (have && e.mv && move_done) begin
                    chk("turn_after_move", turn, e.t);
                    chk("move_count", move_count, e.cnt);
                    chk("game_over", game_over, e.ov);
                end
            end
            if (rd_go_d && rdq.size() > 0)
                chk("rd_piece", rd_piece, rdq.pop_front());
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic idle(int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic pulse_sel(int r, int c, bit cx);
        @(posedge clk); #1;
        cur_row = 3'(r); cur_col = 3'(c);
        select = 1'b1; cancel = cx;
        @(posedge clk); #1;
        select = 1'b0; cancel = 1'b0;
    endtask

    task automatic read_sq(int r, int c, logic [4:0] exp);
        @(posedge clk); #1;
        rd_row = 3'(r); rd_col = 3'(c);
        rdq.push_back(exp); rd_go = 1'b1;
        @(posedge clk); #1;
        rd_go = 1'b0;
        idle(1);
    endtask

    task automatic read_all();
        for (int i = 0; i < 64; i++) begin
            @(posedge clk); #1;
            rd_row = 3'(i / 8); rd_col = 3'(i % 8);
            rdq.push_back(board[i]); rd_go = 1'b1;
        end
        @(posedge clk); #1;
        rd_go = 1'b0;
        idle(1);
    endtask

    task automatic query(int s, logic [63:0] m, int dly);
        int n = 0;
        pulse_sel(s / 8, s % 8, 0);
        while (!src_valid && n < 8) begin @(posedge clk); #1; n++; end
        chk("src_valid_seen", src_valid, 1);
        chk("src_square", {src_row, src_col}, s);
        repeat (dly) begin @(posedge clk); #1; end
        legal_mask = m; legal_valid = 1'b1;
        @(posedge clk); #1;
        legal_valid = 1'b0;
        chk("pick_active", sel_active, 1);
    endtask

    task automatic do_move(int s, int d);
        query(s, 64'd1 << d, $urandom % 4);
        apply_move(s, d);
        pulse_sel(d / 8, d % 8, 0);
        idle(4);
    endtask

    task automatic gen_mask(output logic [63:0] m);
        int d;
        m = '0;
        repeat (1 + $urandom % 4) begin
            d = $urandom % 64;
            if (!own(d)) m[d] = 1'b1;
        end
        for (int i = 0; i < 64 && m == 0; i++)
            if (!own(i)) m[i] = 1'b1;
    endtask

    task automatic play_turn();
        int q[$];
        int s, d, act;
        logic [63:0] m;
        if (mover) begin
            pulse_sel($urandom % 8, $urandom % 8, 1'($urandom % 2));
            idle(2);
            chk("over_src_valid", src_valid, 0);
            chk("over_sel_active", sel_active, 0);
            return;
        end
        if ($urandom % 3 == 0) begin
            q = {};
            for (int i = 0; i < 64; i++) if (!own(i)) q.push_back(i);
            d = q[$urandom % q.size()];
            push_ill();
            pulse_sel(d / 8, d % 8, 0);
            idle(2);
        end
        q = {};
        for (int i = 0; i < 64; i++) if (own(i)) q.push_back(i);
        s = q[$urandom % q.size()];
        gen_mask(m);
        query(s, m, $urandom % 5);
        for (int k = 0; k < 6; k++) begin
            act = $urandom % 6;
            q = {};
            if (act == 0) begin
                for (int i = 0; i < 64; i++) if (!own(i) && !m[i]) q.push_back(i);
                if (q.size() > 0) begin
                    d = q[$urandom % q.size()];
                    push_ill();
                    pulse_sel(d / 8, d % 8, 0);
                    idle(2);
                    chk("pick_hold", sel_active, 1);
                end
            end else if (act == 1) begin
                pulse_sel($urandom % 8, $urandom % 8, 1);
                idle(2);
                chk("cancel_idle", sel_active, 0);
                return;
            end else if (act == 2) begin
                pulse_sel(s / 8, s % 8, 0);
                idle(2);
                chk("deselect_idle", sel_active, 0);
                return;
            end else if (act == 3) begin
                for (int i = 0; i < 64; i++) if (own(i) && i != s) q.push_back(i);
                if (q.size() > 0) begin
                    s = q[$urandom % q.size()];
                    gen_mask(m);
                    query(s, m, $urandom % 5);
                end
            end else begin
                for (int i = 0; i < 64; i++) if (m[i]) q.push_back(i);
                d = q[$urandom % q.size()];
                apply_move(s, d);
                pulse_sel(d / 8, d % 8, 0);
                idle(4);
                return;
            end
        end
        pulse_sel(0, 0, 1);
        idle(2);
    endtask

    initial begin : stim
        int n;
        model_reset();
        #1;
        chk("reset_rd_piece", rd_piece, 0);
        chk("reset_turn", turn, 0);
        chk("reset_outputs", {src_valid, sel_active, move_done, illegal,
                              game_over, src_row, src_col}, 0);
        chk("reset_count", move_count, 0);
        idle(2);
        @(negedge clk) reset = 1'b0;
        read_sq(7, 4, 5'b11001);
        read_sq(0, 3, 5'b10111);
        read_sq(6, 0, 5'b00101);
        read_sq(3, 3, 5'b00000);
        read_all();

        query(52, (64'd1 << 36) | (64'd1 << 44), 2);
        apply_move(52, 36);
        pulse_sel(4, 4, 0);
        idle(4);
        read_sq(4, 4, 5'b00101);
        read_sq(6, 4, 5'b00000);
        chk("e4_turn", turn, 1);
        chk("e4_count", move_count, 1);

        do_move(3, 24);

        push_ill();
        pulse_sel(1, 0, 0);
        idle(2);
        chk("opp_sel_idle", {sel_active, src_valid}, 0);
        push_ill();
        pulse_sel(3, 3, 0);
        idle(2);
        chk("empty_sel_idle", {sel_active, src_valid}, 0);

        push_ill();
        pulse_sel(7, 1, 0);
        n = 0;
        while (src_valid && n < QT + 10) begin n++; @(posedge clk); #1; end
        chk("timeout_cycles", n, QT);
        chk("timeout_src_valid", src_valid, 0);
        idle(2);

        query(57, (64'd1 << 40) | (64'd1 << 42), 1);
        push_ill();
        pulse_sel(5, 1, 0);
        idle(2);
        chk("mask0_stays_pick", sel_active, 1);
        pulse_sel(5, 0, 1);
        idle(2);
        chk("cancel_wins", sel_active, 0);
        chk("cancel_no_move", {turn, move_count}, 2);

        do_move(50, 10);
        do_move(4, 3);
        do_move(10, 3);
        chk("king_capture_over", game_over, 1);
        read_sq(0, 3, 5'b10101);
        pulse_sel(6, 0, 0);
        idle(2);
        chk("over_ignores", {src_valid, sel_active}, 0);
        read_all();

        @(negedge clk) reset = 1'b1;
        model_reset();
        @(negedge clk) reset = 1'b0;
        pulse_sel(6, 0, 0);
        chk("query_before_reset", src_valid, 1);
        reset = 1'b1;
        #1;
        chk("reset_mid_query", {src_valid, turn, game_over}, 0);
        @(negedge clk) reset = 1'b0;
        read_all();
        chk("reset_turn_white", turn, 0);

        repeat (40) play_turn();
        read_all();

        idle(3);
        chk("events_drained", evq.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
